cv32e40x_store_buffer: RTL and testbench

Single-entry store buffer with an outstanding-transaction counter. It sits between the data-side MPU bus request output and the data OBI interface. Bufferable stores are accepted from the MPU even while the bus stalls, and issued later in order. It also limits and reports the number of in-flight OBI transactions, which the LSU uses to generate its pending-transaction indications.

---
 rtl/cv32e40x_store_buffer.sv | 117 +++++++++++
 tb/tb_cv32e40x_store_buffer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_store_buffer.sv
// Single-entry store buffer between the data-side MPU and the OBI interface.
// It also limits and reports the number of in-flight OBI transactions.

package cv32e40x_store_buffer_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  memtype;
    logic [2:0]  prot;
  } obi_data_req_t;
endpackage

module cv32e40x_store_buffer
  import cv32e40x_store_buffer_pkg::*;
#(
  parameter type TRANS_TYPE      = obi_data_req_t,
  parameter int  MAX_OUTSTANDING = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trans_valid_i,
  output logic       trans_ready_o,
  input  TRANS_TYPE  trans_i,
  output logic       bus_trans_valid_o,
  input  logic       bus_trans_ready_i,
  output TRANS_TYPE  bus_trans_o,
  input  logic       bus_resp_valid_i,
  output logic [1:0] cnt_o,
  output logic       empty_o
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  typedef enum logic {
    WB_EMPTY,
    WB_FULL
  } state_e;

  state_e     state_q;
  state_e     state_n;
  TRANS_TYPE  buf_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_n;
  logic       issue_ok;
  logic       bufferable;
  logic       capture;
  logic       bus_fire;

  assign issue_ok   = (cnt_q < MAX_CNT);
  assign bufferable = trans_i.we && trans_i.memtype[0];
  assign bus_fire   = bus_trans_valid_o && bus_trans_ready_i;

  // In WB_FULL every new request is held off so the buffered store stays ahead.
  always_comb begin
    state_n           = state_q;
    bus_trans_o       = trans_i;
    bus_trans_valid_o = 1'b0;
    trans_ready_o     = 1'b0;
    capture           = 1'b0;
    unique case (state_q)
      WB_EMPTY: begin
        bus_trans_o       = trans_i;
        bus_trans_valid_o = trans_valid_i && issue_ok;
        trans_ready_o     = bufferable ? 1'b1 : (bus_trans_ready_i && issue_ok);
        if (trans_valid_i && bufferable && !(bus_trans_ready_i && issue_ok)) begin
          capture = 1'b1;
          state_n = WB_FULL;
        end
      end
      WB_FULL: begin
        bus_trans_o       = buf_q;
        bus_trans_valid_o = issue_ok;
        trans_ready_o     = 1'b0;
        if (bus_trans_ready_i && issue_ok) begin
          state_n = WB_EMPTY;
        end
      end
      default: state_n = WB_EMPTY;
    endcase
  end

  always_comb begin
    cnt_n = cnt_q + 2'(bus_fire) - 2'(bus_resp_valid_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WB_EMPTY;
      buf_q   <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (capture) begin
        buf_q <= trans_i;
      end
    end
  end

  assign cnt_o   = cnt_q;
  assign empty_o = (state_q == WB_EMPTY);

  // Protocol checks on both sides of the buffer.
  a_resp_without_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n) bus_resp_valid_i |-> (cnt_q != 2'd0));

  a_trans_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (trans_valid_i && !trans_ready_o) |=> $stable(trans_i));

  a_bus_trans_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (bus_trans_valid_o && !bus_trans_ready_i) |=> $stable(bus_trans_o));

endmodule

// File: tb/tb_cv32e40x_store_buffer.sv
// Testbench for cv32e40x_store_buffer: directed scenarios with literal
// expectations, then random traffic checked against a transaction-level model.

module tb_cv32e40x_store_buffer;
  import cv32e40x_store_buffer_pkg::*;

  localparam int MAX = 2;

  logic          clk;
  logic          rst_n;
  logic          trans_valid;
  logic          trans_ready;
  obi_data_req_t trans;
  logic          bus_valid;
  logic          bus_ready;
  obi_data_req_t bus_trans;
  logic          resp_valid;
  logic [1:0]    cnt;
  logic          empty;

  int tests = 0;
  int fails = 0;

  cv32e40x_store_buffer #(
    .TRANS_TYPE      (obi_data_req_t),
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .trans_valid_i     (trans_valid),
    .trans_ready_o     (trans_ready),
    .trans_i           (trans),
    .bus_trans_valid_o (bus_valid),
    .bus_trans_ready_i (bus_ready),
    .bus_trans_o       (bus_trans),
    .bus_resp_valid_i  (resp_valid),
    .cnt_o             (cnt),
    .empty_o           (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a buffer flag, an in-flight count and an ordered
  // queue of accepted requests that must appear on the bus in order.
  bit            m_full = 1'b0;
  obi_data_req_t m_buf;
  int            m_cnt = 0;
  obi_data_req_t sb[$];
  bit            pend = 1'b0;
  bit            e_ok, e_bv, e_tr, e_buff;
  obi_data_req_t e_bus;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_full = 1'b0;
      m_cnt  = 0;
      pend   = 1'b0;
      sb.delete();
      check("reset_cnt", 96'(cnt), 96'd0);
      check("reset_empty", 96'(empty), 96'd1);
    end else begin
      e_ok   = (m_cnt < MAX);
      e_buff = trans.we && trans.memtype[0];
      if (!m_full) begin
        e_bus = trans;
        e_bv  = trans_valid && e_ok;
        e_tr  = e_buff ? 1'b1 : (bus_ready && e_ok);
      end else begin
        e_bus = m_buf;
        e_bv  = e_ok;
        e_tr  = 1'b0;
      end
      check("cnt", 96'(cnt), 96'(m_cnt));
      check("empty", 96'(empty), 96'(!m_full));
      check("bus_valid", 96'(bus_valid), 96'(e_bv));
      check("trans_ready", 96'(trans_ready), 96'(e_tr));
      if (e_bv) check("bus_trans", 96'(bus_trans), 96'(e_bus));

      if (trans_valid && e_tr) sb.push_back(trans);
      if (e_bv && bus_ready) begin
        if (sb.size() == 0) begin
          check("order_underflow", 96'd1, 96'd0);
        end else begin
          check("order", 96'(bus_trans), 96'(sb.pop_front()));
        end
      end

      if (m_full && bus_ready && e_ok) begin
        m_full = 1'b0;
      end else if (!m_full && trans_valid && e_buff && !(bus_ready && e_ok)) begin
        m_full = 1'b1;
        m_buf  = trans;
      end
      m_cnt = m_cnt + ((e_bv && bus_ready) ? 1 : 0) - (resp_valid ? 1 : 0);
      pend  = trans_valid && !e_tr;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    trans_valid = 1'b0;
    bus_ready   = 1'b0;
    resp_valid  = 1'b0;
  endtask

  function automatic obi_data_req_t mk(input logic we, input logic [31:0] addr);
    obi_data_req_t r;
    r.addr    = addr;
    r.we      = we;
    r.be      = 4'hf;
    r.wdata   = ~addr;
    r.memtype = we ? 2'b01 : 2'b00;
    r.prot    = 3'b011;
    return r;
  endfunction

  function automatic obi_data_req_t rand_req();
    obi_data_req_t r;
    r.addr    = $urandom;
    r.we      = 1'($urandom);
    r.be      = 4'($urandom);
    r.wdata   = $urandom;
    r.memtype = 2'($urandom);
    r.prot    = 3'($urandom);
    return r;
  endfunction

  obi_data_req_t ld0, ld1, ld2, ld3, ld4, st0, st1;

  initial begin
    ld0 = mk(1'b0, 32'h1000);
    ld1 = mk(1'b0, 32'h1004);
    ld2 = mk(1'b0, 32'h1008);
    ld3 = mk(1'b0, 32'h100c);
    ld4 = mk(1'b0, 32'h1010);
    st0 = mk(1'b1, 32'h2000);
    st1 = mk(1'b1, 32'h2004);

    rst_n = 1'b0;
    trans = '0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("init_cnt", 96'(cnt), 96'd0);
    check("init_empty", 96'(empty), 96'd1);
    check("init_bus_valid", 96'(bus_valid), 96'd0);
    cyc();

    // Load passes straight through, then its response retires it.
    trans = ld0; trans_valid = 1'b1; bus_ready = 1'b1;
    @(negedge clk);
    check("s1_ready", 96'(trans_ready), 96'd1);
    check("s1_bus_valid", 96'(bus_valid), 96'd1);
    check("s1_bus_trans", 96'(bus_trans), 96'(ld0));
    check("s1_cnt0", 96'(cnt), 96'd0);
    cyc();
    idle(); resp_valid = 1'b1;
    @(negedge clk);
    check("s1_cnt1", 96'(cnt), 96'd1);
    check("s1_empty", 96'(empty), 96'd1);
    cyc();
    resp_valid = 1'b0;
    @(negedge clk);
    check("s1_cnt_back", 96'(cnt), 96'd0);
    cyc();

    // Bufferable store under a three-cycle bus stall.
    trans = st0; trans_valid = 1'b1; bus_ready = 1'b0;
    @(negedge clk);
    check("s2_ready_c0", 96'(trans_ready), 96'd1);
    check("s2_empty_c0", 96'(empty), 96'd1);
    cyc();
    trans_valid = 1'b0;
    @(negedge clk);
    check("s2_empty_c1", 96'(empty), 96'd0);
    check("s2_bus_trans_c1", 96'(bus_trans), 96'(st0));
    check("s2_bus_valid_c1", 96'(bus_valid), 96'd1);
    cyc();
    @(negedge clk);
    check("s2_bus_trans_c2", 96'(bus_trans), 96'(st0));
    cyc();
    bus_ready = 1'b1;
    @(negedge clk);
    check("s2_bus_trans_c3", 96'(bus_trans), 96'(st0));
    cyc();
    bus_ready = 1'b0; resp_valid = 1'b1;
    @(negedge clk);
    check("s2_empty_c4", 96'(empty), 96'd1);
    check("s2_cnt_c4", 96'(cnt), 96'd1);
    cyc();
    resp_valid = 1'b0;
    cyc();

    // Load waits behind a buffered store and issues only after the drain.
    trans = st1; trans_valid = 1'b1; bus_ready = 1'b0;
    @(negedge clk);
    check("s3_store_ready", 96'(trans_ready), 96'd1);
    cyc();
    trans = ld1;
    @(negedge clk);
    check("s3_blocked0", 96'(trans_ready), 96'd0);
    check("s3_bus_trans", 96'(bus_trans), 96'(st1));
    cyc();
    @(negedge clk);
    check("s3_blocked1", 96'(trans_ready), 96'd0);
    cyc();
    bus_ready = 1'b1;
    @(negedge clk);
    check("s3_drain_blocked", 96'(trans_ready), 96'd0);
    check("s3_drain_trans", 96'(bus_trans), 96'(st1));
    cyc();
    @(negedge clk);
    check("s3_load_ready", 96'(trans_ready), 96'd1);
    check("s3_load_trans", 96'(bus_trans), 96'(ld1));
    check("s3_cnt", 96'(cnt), 96'd1);
    cyc();
    idle(); resp_valid = 1'b1;
    @(negedge clk);
    check("s3_cnt2", 96'(cnt), 96'd2);
    cyc();
    cyc();
    resp_valid = 1'b0;
    @(negedge clk);
    check("s3_cnt_back", 96'(cnt), 96'd0);
    cyc();

    // Outstanding limit: third load stalls until a response frees a slot.
    trans = ld2; trans_valid = 1'b1; bus_ready = 1'b1;
    cyc();
    trans = ld3;
    cyc();
    trans = ld4;
    @(negedge clk);
    check("s4_cnt_max", 96'(cnt), 96'd2);
    check("s4_gated", 96'(bus_valid), 96'd0);
    check("s4_stalled", 96'(trans_ready), 96'd0);
    cyc();
    resp_valid = 1'b1;
    @(negedge clk);
    check("s4_not_comb", 96'(bus_valid), 96'd0);
    cyc();
    resp_valid = 1'b0;
    @(negedge clk);
    check("s4_freed_valid", 96'(bus_valid), 96'd1);
    check("s4_freed_trans", 96'(bus_trans), 96'(ld4));
    check("s4_cnt1", 96'(cnt), 96'd1);
    cyc();

    // Simultaneous accept and response keeps the count.
    idle(); resp_valid = 1'b1;
    cyc();
    trans = ld0; trans_valid = 1'b1; bus_ready = 1'b1; resp_valid = 1'b1;
    @(negedge clk);
    check("s5_cnt_before", 96'(cnt), 96'd1);
    cyc();
    idle();
    @(negedge clk);
    check("s5_cnt_after", 96'(cnt), 96'd1);
    cyc();

    // Reset while holding a store with the bus at its limit.
    trans = ld1; trans_valid = 1'b1; bus_ready = 1'b1;
    cyc();
    trans = st0;
    @(negedge clk);
    check("s6_capture_ready", 96'(trans_ready), 96'd1);
    cyc();
    idle();
    @(negedge clk);
    check("s6_full", 96'(empty), 96'd0);
    check("s6_cnt", 96'(cnt), 96'd2);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_empty", 96'(empty), 96'd1);
    check("s6_rst_cnt", 96'(cnt), 96'd0);
    check("s6_rst_bus_valid", 96'(bus_valid), 96'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc();

    // Random traffic, legal on both handshakes.
    for (int i = 0; i < 3000; i++) begin
      if (!pend) begin
        trans       = rand_req();
        trans_valid = ($urandom_range(0, 2) != 0);
      end
      bus_ready  = 1'($urandom);
      resp_valid = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
      cyc();
    end

    idle();
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
